// File: rtl/chimp_sequence_ctrl.sv
// -----------------------------------------------------------------------------
// chimp_sequence_ctrl
//   Control path for the chimp memory game. Loads `level` numbered tiles into
//   the display datapath, waits for the player to start, then checks presses
//   in order 1..level. A clean run advances the level, and clearing MAX_LEVEL
//   wins. A wrong press costs a strike and reloads the same level. Reaching
//   LIVES strikes loses the game.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   iKey0      : asynchronous active-high reset, returns the block to IDLE
//   iEnter     : one-cycle start/confirm pulse
//   iPressNum  : tile number pressed; 0 means no press this cycle
//   oState     : IDLE=0, LOAD=1, READY=2, CHOOSE=3, LOST=4, WON=5
//   oLoadValid : high in LOAD; the datapath places tile oLoadIdx
//   oLoadIdx   : tile number being loaded in LOAD, else 0
//   oLevel     : current tile count
//   oExpected  : next correct press in CHOOSE, else 0
//   oHide      : tiles blanked (CHOOSE after the first correct press)
//   oStrikes   : wrong presses this game
//   oScore     : highest level cleared this game
//   oLost/oWon : game-over flags
// -----------------------------------------------------------------------------
module chimp_sequence_ctrl #(
    parameter int MAX_LEVEL   = 31,
    parameter int START_LEVEL = 4,
    parameter int LIVES       = 3,
    parameter int PW          = 6
) (
    input  logic          clk,
    input  logic          iKey0,
    input  logic          iEnter,
    input  logic [PW-1:0] iPressNum,
    output logic [2:0]    oState,
    output logic          oLoadValid,
    output logic [PW-1:0] oLoadIdx,
    output logic [PW-1:0] oLevel,
    output logic [PW-1:0] oExpected,
    output logic          oHide,
    output logic [2:0]    oStrikes,
    output logic [PW-1:0] oScore,
    output logic          oLost,
    output logic          oWon
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_READY  = 3'd2,
        S_CHOOSE = 3'd3,
        S_LOST   = 3'd4,
        S_WON    = 3'd5
    } state_e;

    localparam logic [PW-1:0] LVL_START  = PW'(START_LEVEL);
    localparam logic [PW-1:0] LVL_MAX    = PW'(MAX_LEVEL);
    localparam logic [PW-1:0] ONE        = PW'(1);
    localparam logic [2:0]    STRIKE_MAX = 3'(LIVES);

    state_e        state_q, state_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [PW-1:0] expected_q, expected_d;
    logic [2:0]    strikes_q, strikes_d;
    logic [PW-1:0] score_q, score_d;

    always_comb begin
        // NOTE: every _d starts as its _q so that no path leaves a variable
        // unassigned; that is what keeps this block free of inferred latches.
        state_d    = state_q;
        level_d    = level_q;
        idx_d      = idx_q;
        expected_d = expected_q;
        strikes_d  = strikes_q;
        score_d    = score_q;

        case (state_q)
            S_IDLE: begin
                if (iEnter) begin
                    state_d   = S_LOAD;
                    level_d   = LVL_START;
                    idx_d     = ONE;
                    strikes_d = '0;
                    score_d   = '0;
                end
            end

            // One tile per cycle, so LOAD lasts exactly `level` cycles.
            S_LOAD: begin
                if (idx_q < level_q) begin
                    idx_d = idx_q + ONE;
                end else begin
                    state_d = S_READY;
                end
            end

            S_READY: begin
                if (iEnter) begin
                    state_d    = S_CHOOSE;
                    expected_d = ONE;
                end
            end

            // iEnter is deliberately ignored here; only presses matter.
            S_CHOOSE: begin
                if (iPressNum != '0) begin
                    if (iPressNum == expected_q) begin
                        if (expected_q < level_q) begin
                            expected_d = expected_q + ONE;
                        end else begin
                            // Last tile of the level hit: bank the score.
                            score_d    = level_q;
                            expected_d = '0;
                            if (level_q == LVL_MAX) begin
                                state_d = S_WON;
                            end else begin
                                state_d = S_LOAD;
                                level_d = level_q + ONE;
                                idx_d   = ONE;
                            end
                        end
                    end else begin
                        // Any other nonzero value, including ones above level.
                        strikes_d  = strikes_q + 3'd1;
                        expected_d = '0;
                        if (strikes_d == STRIKE_MAX) begin
                            state_d = S_LOST;
                        end else begin
                            state_d = S_LOAD;
                            idx_d   = ONE;
                        end
                    end
                end
            end

            // level, score and strikes stay put for the display.
            S_LOST, S_WON: begin
                if (iEnter) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d from the same pre-edge values.
    always_ff @(posedge clk or posedge iKey0) begin
        if (iKey0) begin
            state_q    <= S_IDLE;
            level_q    <= LVL_START;
            idx_q      <= '0;
            expected_q <= '0;
            strikes_q  <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            expected_q <= expected_d;
            strikes_q  <= strikes_d;
            score_q    <= score_d;
        end
    end

    // Moore outputs, decoded from registers only.
    assign oState     = state_q;
    assign oLoadValid = (state_q == S_LOAD);
    assign oLoadIdx   = (state_q == S_LOAD) ? idx_q : '0;
    assign oLevel     = level_q;
    assign oExpected  = (state_q == S_CHOOSE) ? expected_q : '0;
    assign oHide      = (state_q == S_CHOOSE) && (expected_q > ONE);
    assign oStrikes   = strikes_q;
    assign oScore     = score_q;
    assign oLost      = (state_q == S_LOST);
    assign oWon       = (state_q == S_WON);

endmodule
